// File: rtl/fp_mul_pipe.sv
// fp_mul_pipe: parametrised IEEE-754-style floating-point multiplier.
// Multi-cycle FSM, one operation in flight, round-to-nearest-even,
// full special-case handling and exception flags.
//
// Parameters:
//   EXP_W   exponent field width (>= 3)
//   MAN_W   stored fraction width (>= 2); word width W = 1+EXP_W+MAN_W
// Ports:
//   clk, rst_n          rising-edge clock, asynchronous active-low reset
//   in_valid/in_ready   operand handshake (in_ready only in IDLE)
//   x_data, y_data      operands {sign, exponent, fraction}
//   z_data              result, stable while out_valid is high
//   z_flags             {invalid, overflow, underflow, inexact}
//   out_valid/out_ready result handshake
// Build option:
//   FP_MUL_SUBNORMAL_EN defined  -> subnormal inputs normalised (NORM),
//                                   subnormal outputs produced (DENORM)
//   FP_MUL_SUBNORMAL_EN undefined-> subnormal inputs read as signed zero,
//                                   tiny results flushed to signed zero
module fp_mul_pipe #(
    parameter int EXP_W = 8,
    parameter int MAN_W = 23
) (
    input  logic                   clk,
    input  logic                   rst_n,
    input  logic                   in_valid,
    output logic                   in_ready,
    input  logic [EXP_W+MAN_W:0]   x_data,
    input  logic [EXP_W+MAN_W:0]   y_data,
    output logic [EXP_W+MAN_W:0]   z_data,
    output logic [3:0]             z_flags,
    output logic                   out_valid,
    input  logic                   out_ready
);
    localparam int W    = 1 + EXP_W + MAN_W;
    localparam int EW   = EXP_W + 2;
    localparam int MW1  = MAN_W + 1;
    localparam int PW   = 2 * MW1;
    localparam int BIAS = (1 << (EXP_W - 1)) - 1;
    localparam logic signed [EW-1:0] EMIN  = EW'(1 - BIAS);
    localparam logic signed [EW-1:0] EBIAS = EW'(BIAS);
    localparam logic signed [EW-1:0] EOVF  = EW'((1 << EXP_W) - 1);
    localparam logic signed [EW-1:0] ONE   = EW'(1);
    localparam logic [W-1:0] QNAN = {1'b0, {EXP_W{1'b1}}, 1'b1, {(MAN_W-1){1'b0}}};
`ifdef FP_MUL_SUBNORMAL_EN
    localparam int CNT_W = $clog2(MAN_W + 4);
    localparam logic [CNT_W-1:0] DCAP = CNT_W'(MAN_W + 3);
`endif

    typedef enum logic [3:0] {
        S_IDLE,
        S_UNPACK,
        S_SPECIAL,
`ifdef FP_MUL_SUBNORMAL_EN
        S_NORM,
        S_DENORM,
`endif
        S_MUL,
        S_ALIGN,
        S_ROUND,
        S_PACK,
        S_DONE
    } state_t;

    state_t state, state_n;

    logic [W-1:0]           x_r, y_r;
    logic                   xs, ys, zs;
    logic signed [EW-1:0]   xe, ye, ze;
    logic [MW1-1:0]         xm, ym, zm;
    logic [PW-1:0]          prod;
    logic                   g, r, st, tiny, inx;
`ifdef FP_MUL_SUBNORMAL_EN
    logic [CNT_W-1:0]       dcnt;
    logic [MW1-1:0]         xm_sh, ym_sh;
`endif

    logic [EXP_W-1:0]       x_exp, y_exp;
    logic [MAN_W-1:0]       x_frac, y_frac;
    logic                   x_nan, y_nan, x_inf, y_inf, x_zero, y_zero, is_special;
    logic signed [EW-1:0]   ze_al, e_b;
    logic                   rnd_inc;
    logic [MW1:0]           rsum;

    assign x_exp  = x_r[W-2 -: EXP_W];
    assign y_exp  = y_r[W-2 -: EXP_W];
    assign x_frac = x_r[MAN_W-1:0];
    assign y_frac = y_r[MAN_W-1:0];
    assign x_nan  = (&x_exp) && (|x_frac);
    assign y_nan  = (&y_exp) && (|y_frac);
    assign x_inf  = (&x_exp) && !(|x_frac);
    assign y_inf  = (&y_exp) && !(|y_frac);
`ifdef FP_MUL_SUBNORMAL_EN
    assign x_zero = (x_exp == '0) && (x_frac == '0);
    assign y_zero = (y_exp == '0) && (y_frac == '0);
    assign xm_sh  = xm[MAN_W] ? xm : (xm << 1);
    assign ym_sh  = ym[MAN_W] ? ym : (ym << 1);
`else
    assign x_zero = (x_exp == '0);
    assign y_zero = (y_exp == '0);
`endif
    assign is_special = x_nan | y_nan | x_inf | y_inf | x_zero | y_zero;

    // Product of two [1,2) significands lies in [1,4); MSB set means >= 2.
    assign ze_al   = prod[PW-1] ? (ze + ONE) : ze;
    assign rnd_inc = g & (r | st | zm[0]);
    assign rsum    = {1'b0, zm} + {{MW1{1'b0}}, rnd_inc};
    assign e_b     = ze + EBIAS;

    assign in_ready  = (state == S_IDLE);
    assign out_valid = (state == S_DONE);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state <= S_IDLE;
        else        state <= state_n;
    end

    always_comb begin
        state_n = state;
        case (state)
            S_IDLE:    if (in_valid) state_n = S_UNPACK;
            S_UNPACK:  state_n = S_SPECIAL;
            S_SPECIAL: begin
                if (is_special)                   state_n = S_DONE;
`ifdef FP_MUL_SUBNORMAL_EN
                else if (!xm[MAN_W] || !ym[MAN_W]) state_n = S_NORM;
`endif
                else                              state_n = S_MUL;
            end
`ifdef FP_MUL_SUBNORMAL_EN
            S_NORM:    if (xm_sh[MAN_W] && ym_sh[MAN_W]) state_n = S_MUL;
            S_DENORM:  if ((ze + ONE) >= EMIN || dcnt == DCAP - 1'b1) state_n = S_ROUND;
`endif
            S_MUL:     state_n = S_ALIGN;
`ifdef FP_MUL_SUBNORMAL_EN
            S_ALIGN:   state_n = (ze_al < EMIN) ? S_DENORM : S_ROUND;
`else
            S_ALIGN:   state_n = S_ROUND;
`endif
            S_ROUND:   state_n = S_PACK;
            S_PACK:    state_n = S_DONE;
            S_DONE:    if (out_ready) state_n = S_IDLE;
            default:   state_n = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            x_r <= '0; y_r <= '0;
            xs <= 1'b0; ys <= 1'b0; zs <= 1'b0;
            xe <= '0; ye <= '0; ze <= '0;
            xm <= '0; ym <= '0; zm <= '0;
            prod <= '0;
            g <= 1'b0; r <= 1'b0; st <= 1'b0; tiny <= 1'b0; inx <= 1'b0;
`ifdef FP_MUL_SUBNORMAL_EN
            dcnt <= '0;
`endif
            z_data <= '0;
            z_flags <= '0;
        end else begin
            case (state)
                S_IDLE: if (in_valid) begin
                    x_r <= x_data;
                    y_r <= y_data;
                end
                S_UNPACK: begin
                    xs <= x_r[W-1];
                    ys <= y_r[W-1];
                    xe <= (x_exp == '0) ? EMIN : (signed'({2'b00, x_exp}) - EBIAS);
                    ye <= (y_exp == '0) ? EMIN : (signed'({2'b00, y_exp}) - EBIAS);
                    xm <= {x_exp != '0, x_frac};
                    ym <= {y_exp != '0, y_frac};
`ifdef FP_MUL_SUBNORMAL_EN
                    dcnt <= '0;
`endif
                end
                S_SPECIAL: begin
                    if (x_nan || y_nan || ((x_inf || y_inf) && (x_zero || y_zero))) begin
                        z_data  <= QNAN;
                        z_flags <= 4'b1000;
                    end else if (x_inf || y_inf) begin
                        z_data  <= {xs ^ ys, {EXP_W{1'b1}}, {MAN_W{1'b0}}};
                        z_flags <= 4'b0000;
                    end else if (x_zero || y_zero) begin
                        z_data  <= {xs ^ ys, {(W-1){1'b0}}};
                        z_flags <= 4'b0000;
                    end
                end
`ifdef FP_MUL_SUBNORMAL_EN
                S_NORM: begin
                    xm <= xm_sh;
                    ym <= ym_sh;
                    if (!xm[MAN_W]) xe <= xe - ONE;
                    if (!ym[MAN_W]) ye <= ye - ONE;
                end
`endif
                S_MUL: begin
                    ze   <= xe + ye;
                    zs   <= xs ^ ys;
                    prod <= PW'(xm) * PW'(ym);
                end
                S_ALIGN: begin
                    ze   <= ze_al;
                    tiny <= (ze_al < EMIN);
                    if (prod[PW-1]) begin
                        zm <= prod[PW-1 -: MW1];
                        g  <= prod[PW-1-MW1];
                        r  <= prod[PW-2-MW1];
                        st <= |prod[PW-3-MW1:0];
                    end else begin
                        zm <= prod[PW-2 -: MW1];
                        g  <= prod[PW-2-MW1];
                        r  <= prod[PW-3-MW1];
                        st <= |prod[PW-4-MW1:0];
                    end
                end
`ifdef FP_MUL_SUBNORMAL_EN
                S_DENORM: begin
                    dcnt <= dcnt + 1'b1;
                    // On the last permitted shift every significand bit has
                    // already passed into sticky; pin the exponent at EMIN.
                    if (dcnt == DCAP - 1'b1 && (ze + ONE) < EMIN) begin
                        zm <= '0; g <= 1'b0; r <= 1'b0; st <= 1'b1;
                        ze <= EMIN;
                    end else begin
                        zm <= zm >> 1;
                        g  <= zm[0];
                        r  <= g;
                        st <= st | r;
                        ze <= ze + ONE;
                    end
                end
`endif
                S_ROUND: begin
                    inx <= g | r | st;
                    if (rsum[MW1]) begin
                        zm <= rsum[MW1:1];
                        ze <= ze + ONE;
                    end else begin
                        zm <= rsum[MW1-1:0];
                    end
                end
                S_PACK: begin
                    if (e_b >= EOVF) begin
                        z_data  <= {zs, {EXP_W{1'b1}}, {MAN_W{1'b0}}};
                        z_flags <= 4'b0101;
                    end
`ifndef FP_MUL_SUBNORMAL_EN
                    else if (ze < EMIN) begin
                        z_data  <= {zs, {(W-1){1'b0}}};
                        z_flags <= 4'b0011;
                    end
`endif
                    else if (!zm[MAN_W]) begin
                        z_data  <= {zs, {EXP_W{1'b0}}, zm[MAN_W-1:0]};
                        z_flags <= {2'b00, tiny & inx, inx};
                    end else begin
                        z_data  <= {zs, e_b[EXP_W-1:0], zm[MAN_W-1:0]};
                        z_flags <= {2'b00, tiny & inx, inx};
                    end
                end
                default: ;
            endcase
        end
    end
endmodule

// File: doc/fp_mul_pipe.md
# fp_mul_pipe

Parametrised IEEE-754-style floating-point multiplier with valid/ready handshaking on both sides and round-to-nearest-even. It covers full special-case handling and exception flags. It is the next-generation multiplier for the feedforward datapath and is sized by exponent and mantissa width, so one block serves binary16, binary32 and custom formats. Implementation is a multi-cycle FSM with one operation in flight.

## Interface
- `EXP_W`, 8, exponent field width (≥3)
- `MAN_W`, 23, stored fraction width (≥2); word width `W = 1+EXP_W+MAN_W`
- `clk`  in  1  rising-edge clock
- `rst_n`  in  1  asynchronous active-low reset
- `in_valid`  in  1  operands valid
- `in_ready`  out  1  block can accept operands
- `x_data`, `y_data`  in  W  operands {sign, exponent, fraction}
- `z_data`  out  W  result
- `z_flags`  out  4  {invalid, overflow, underflow, inexact}
- `out_valid`  out  1  result valid
- `out_ready`  in  1  consumer accepts result

## Operation
- Reset values: `in_ready`=1, `out_valid`=0, `z_data`=0, `z_flags`=0, state IDLE.
- Bias `B = 2^(EXP_W-1)-1`. Internal exponent is signed, `EXP_W+2` bits. Product is `2*(MAN_W+1)` bits.
- States:
  - **IDLE**: `in_ready`=1. On `in_valid`, latch operands, go to UNPACK.
  - **UNPACK**: split fields, unbias exponents.
  - **SPECIAL**: handle special operands, then go to DONE; otherwise go to NORM.
    - Any NaN, or inf×0 → `z_data` = canonical qNaN (sign 0, exponent all ones, fraction MSB 1, rest 0), invalid=1.
    - inf×finite-nonzero → inf, sign = xs^ys.
    - zero×finite → zero, sign = xs^ys.
  - **NORM**: shift left any operand with hidden bit 0, one bit per cycle, decrementing its exponent. Both operands shift in parallel. Exit when both hidden bits are 1.
  - **MUL**: ze = xe+ye, zs = xs^ys, full product.
  - **ALIGN**: if product MSB is set, take the top `MAN_W+1` bits and ze += 1. Otherwise take the next `MAN_W+1` bits. Derive guard, round and sticky (OR of the remainder).
  - **DENORM**: while ze < 1-B, shift right 1 bit per cycle with ze += 1 and sticky accumulation.
  - **ROUND**: RNE, increment when guard & (round | sticky | lsb). A carry out renormalises (ze += 1). inexact = guard|round|sticky.
  - **PACK**:
    - ze+B ≥ 2^EXP_W−1 → inf, overflow=1, inexact=1.
    - Subnormal result → exponent field 0; underflow=1 iff tiny and inexact.
  - **DONE**: `out_valid`=1. `z_data` and `z_flags` stay stable until `out_ready`, then go to IDLE.
- `in_ready` is 0 in every state except IDLE; a new operation is never accepted in the same cycle a result is consumed.
- Reset asserted mid-operation aborts it immediately; all outputs return to their reset values and no partial result is ever presented.

## Timing
- The cycle count starts at the clock edge on which `in_valid`&`in_ready` is seen.
- Normal×normal giving a normal result: `out_valid` rises 7 edges after acceptance, with `out_ready` held high.
- Special cases: `out_valid` rises 3 edges after acceptance.
- Each leading-zero shift on a subnormal operand adds 1 cycle in NORM; the cost is the larger of the two operands' shift counts.
- Each right shift in DENORM adds 1 cycle, capped at `MAN_W+3` shifts. After the cap, the result is zero with sticky set.
- When the consumer takes the result, `in_ready` returns to 1 on the edge after the `out_valid`&`out_ready` handshake.

## Configuration
- `FP_MUL_SUBNORMAL_EN` defined:
  - Subnormal inputs are normalised in NORM.
  - Subnormal outputs are produced via DENORM.
- Undefined:
  - Subnormal inputs are treated as signed zero.
  - Results below the minimum normal are flushed to signed zero with underflow=1 and inexact=1.
  - The NORM and DENORM states are not compiled.
  - Normal latency is unchanged at 7.

## Test plan
All vectors use the defaults (binary32).
- 0x3FC00000 × 0x40000000 → 0x40400000, flags 0, `out_valid` exactly 7 edges after acceptance.
- 0x7F800000 × 0x00000000 → 0x7FC00000, invalid=1, latency 3. Also 0xFF800000 × 0x40000000 → 0xFF800000, flags 0.
- 0x7F7FFFFF × 0x40000000 → 0x7F800000, overflow=1, inexact=1.
- RNE: 0x3F800001 × 0x3F800001 → 0x3F800002, inexact=1.
- 0x00000001 × 0x4B000000:
  - with macro → 0x00800000, flags 0;
  - without macro → 0x00000000.
- Backpressure and reset:
  - Hold `out_ready`=0 for 5 cycles → `z_data` stable, `in_ready`=0 throughout, `in_valid` pulses ignored.
  - Deassert `rst_n` in MUL → `out_valid`=0 and `in_ready`=1 immediately.
